// File: rtl/operand_fetch_if.sv
// operand_fetch_if: handshake and payload bundle around the operand fetch stage.
//   Decode side : in_valid/in_ready, in_pc, in_imm, in_ctrl, in_rs1/in_rs2,
//                 in_use_rs1/in_use_rs2, in_rd
//   Execute side: out_valid/out_ready, out_pc, out_imm, out_ctrl, out_rd,
//                 out_op1/out_op2
// The slave modport is the operand fetch stage itself; the master modport is
// the surrounding pipeline (decode producing, execute consuming).
interface operand_fetch_if #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [XLEN-1:0]   in_imm;
    logic [CTRL_W-1:0] in_ctrl;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic              in_use_rs1;
    logic              in_use_rs2;
    logic [4:0]        in_rd;

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_imm;
    logic [CTRL_W-1:0] out_ctrl;
    logic [4:0]        out_rd;
    logic [XLEN-1:0]   out_op1;
    logic [XLEN-1:0]   out_op2;

    modport master (
        output in_valid, in_pc, in_imm, in_ctrl, in_rs1, in_rs2,
               in_use_rs1, in_use_rs2, in_rd, out_ready,
        input  in_ready, out_valid, out_pc, out_imm, out_ctrl, out_rd,
               out_op1, out_op2
    );

    modport slave (
        input  in_valid, in_pc, in_imm, in_ctrl, in_rs1, in_rs2,
               in_use_rs1, in_use_rs2, in_rd, out_ready,
        output in_ready, out_valid, out_pc, out_imm, out_ctrl, out_rd,
               out_op1, out_op2
    );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: decode -> execute stage of the RV64 core.
// Reads the integer register file, forwards from EX (highest priority) and MEM,
// stalls decode on load-use / pending-data hazards, and holds the selected
// operands in a single-entry output register toward execute.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   bus                 decode/execute handshakes and payload (slave side)
//   rf_raddr1/2         register file read addresses (combinational)
//   rf_rdata1/2         register file read data (combinational)
//   ex_fwd_*            EX-stage forwarding source
//   mem_fwd_*           MEM-stage forwarding source
//   flush               squash held instruction, block acceptance
//   stall_cnt           saturating count of hazard-stall cycles
module operand_fetch #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    operand_fetch_if.slave    bus,
    output logic [4:0]        rf_raddr1,
    output logic [4:0]        rf_raddr2,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    input  logic              ex_fwd_valid,
    input  logic [4:0]        ex_fwd_rd,
    input  logic              ex_fwd_is_load,
    input  logic [XLEN-1:0]   ex_fwd_data,
    input  logic              mem_fwd_valid,
    input  logic [4:0]        mem_fwd_rd,
    input  logic              mem_fwd_data_ok,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              ex_hit1_s;
    logic              ex_hit2_s;
    logic              mem_hit1_s;
    logic              mem_hit2_s;
    logic              haz1_s;
    logic              haz2_s;
    logic              hazard_s;
    logic              in_ready_s;
    logic              accept_s;
    logic [XLEN-1:0]   op1_s;
    logic [XLEN-1:0]   op2_s;

    logic              out_valid_r;
    logic [XLEN-1:0]   out_pc_r;
    logic [XLEN-1:0]   out_imm_r;
    logic [CTRL_W-1:0] out_ctrl_r;
    logic [4:0]        out_rd_r;
    logic [XLEN-1:0]   out_op1_r;
    logic [XLEN-1:0]   out_op2_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    assign rf_raddr1 = bus.in_rs1;
    assign rf_raddr2 = bus.in_rs2;

    // x0 never matches a producer, so forwarding and hazards ignore it.
    assign ex_hit1_s  = (bus.in_rs1 != 5'd0) && ex_fwd_valid  && (ex_fwd_rd  == bus.in_rs1);
    assign ex_hit2_s  = (bus.in_rs2 != 5'd0) && ex_fwd_valid  && (ex_fwd_rd  == bus.in_rs2);
    assign mem_hit1_s = (bus.in_rs1 != 5'd0) && mem_fwd_valid && (mem_fwd_rd == bus.in_rs1);
    assign mem_hit2_s = (bus.in_rs2 != 5'd0) && mem_fwd_valid && (mem_fwd_rd == bus.in_rs2);

    // A MEM match only matters when EX does not shadow it with a younger write.
    assign haz1_s = bus.in_use_rs1 &&
                    ((ex_hit1_s && ex_fwd_is_load) || (!ex_hit1_s && mem_hit1_s && !mem_fwd_data_ok));
    assign haz2_s = bus.in_use_rs2 &&
                    ((ex_hit2_s && ex_fwd_is_load) || (!ex_hit2_s && mem_hit2_s && !mem_fwd_data_ok));
    assign hazard_s = haz1_s || haz2_s;

    // Ready looks through the output register when EX drains it this cycle.
    assign in_ready_s = !rst && !flush && !hazard_s && (!out_valid_r || bus.out_ready);
    assign accept_s   = bus.in_valid && in_ready_s;

    // rs1 operand select: x0, EX forward, MEM forward, register file.
    always_comb begin
        op1_s = {XLEN{1'b0}};
        if (bus.in_rs1 == 5'd0) begin
            op1_s = {XLEN{1'b0}};
        end else if (ex_hit1_s) begin
            op1_s = ex_fwd_data;
        end else if (mem_hit1_s) begin
            op1_s = mem_fwd_data;
        end else begin
            op1_s = rf_rdata1;
        end
    end

    // rs2 operand select: x0, EX forward, MEM forward, register file.
    always_comb begin
        op2_s = {XLEN{1'b0}};
        if (bus.in_rs2 == 5'd0) begin
            op2_s = {XLEN{1'b0}};
        end else if (ex_hit2_s) begin
            op2_s = ex_fwd_data;
        end else if (mem_hit2_s) begin
            op2_s = mem_fwd_data;
        end else begin
            op2_s = rf_rdata2;
        end
    end

    // Output valid flag: set on accept, cleared on flush or drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Output payload: loads only on accept, otherwise holds (stable under stall).
    always_ff @(posedge clk) begin
        if (rst) begin
            out_pc_r   <= {XLEN{1'b0}};
            out_imm_r  <= {XLEN{1'b0}};
            out_ctrl_r <= {CTRL_W{1'b0}};
            out_rd_r   <= 5'd0;
            out_op1_r  <= {XLEN{1'b0}};
            out_op2_r  <= {XLEN{1'b0}};
        end else if (accept_s) begin
            out_pc_r   <= bus.in_pc;
            out_imm_r  <= bus.in_imm;
            out_ctrl_r <= bus.in_ctrl;
            out_rd_r   <= bus.in_rd;
            out_op1_r  <= op1_s;
            out_op2_r  <= op2_s;
        end
    end

    // Saturating hazard-stall counter; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (bus.in_valid && hazard_s && !flush && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_pc    = out_pc_r;
    assign bus.out_imm   = out_imm_r;
    assign bus.out_ctrl  = out_ctrl_r;
    assign bus.out_rd    = out_rd_r;
    assign bus.out_op1   = out_op1_r;
    assign bus.out_op2   = out_op2_r;
    assign stall_cnt     = stall_cnt_r;

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Pipeline stage between decode and execute in the RV64 core.
- Drives the integer register file read ports and selects final rs1/rs2 operands, forwarding from EX and MEM where needed.
- Detects load-use and pending-data hazards and stalls decode.
- Holds the selected operands in a single-entry output register toward execute, using valid/ready handshakes on both sides.

Parameters:
- XLEN, 64, operand and data width.
- CTRL_W, 32, width of the opaque decoded-control bundle passed through to EX.
- CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  decode presents an instruction.
- in_ready  output  1  stage accepts the instruction this cycle.
- in_pc  input  XLEN  instruction PC.
- in_imm  input  XLEN  sign-extended immediate.
- in_ctrl  input  CTRL_W  decoded control bundle.
- in_rs1, in_rs2  input  5  source register indices.
- in_use_rs1, in_use_rs2  input  1  source operand actually used.
- in_rd  input  5  destination register index.
- rf_raddr1, rf_raddr2  output  5  register file read addresses; combinational copy of in_rs1/in_rs2.
- rf_rdata1, rf_rdata2  input  XLEN  register file read data (combinational).
- ex_fwd_valid  input  1  EX holds an instruction writing ex_fwd_rd.
- ex_fwd_rd  input  5  EX destination register.
- ex_fwd_is_load  input  1  EX instruction is a load; result not yet available.
- ex_fwd_data  input  XLEN  EX ALU result.
- mem_fwd_valid  input  1  MEM holds an instruction writing mem_fwd_rd.
- mem_fwd_rd  input  5  MEM destination register.
- mem_fwd_data_ok  input  1  mem_fwd_data is final; 0 while a load is outstanding.
- mem_fwd_data  input  XLEN  MEM result.
- flush  input  1  squash the held instruction and block acceptance.
- out_valid  output  1  operands valid toward EX.
- out_ready  input  1  EX accepts.
- out_pc, out_imm  output  XLEN  registered copies of in_pc and in_imm.
- out_ctrl  output  CTRL_W  registered copy of in_ctrl.
- out_rd  output  5  registered copy of in_rd.
- out_op1, out_op2  output  XLEN  registered final operands.
- stall_cnt  output  CNT_W  count of hazard-stall cycles.

Behaviour:
- Reset: out_valid=0; out_pc, out_imm, out_ctrl, out_rd, out_op1, out_op2 = 0; stall_cnt=0. rst overrides flush and all handshakes. Reset mid-transfer drops the held instruction.
- Register file write timing: the register file writes on negedge clk. A WB-stage write is visible on rf_rdata the same cycle, so there is no WB forwarding path.
- Operand select, per source s: if rs_s==0, the operand is 0 and no forwarding or hazard applies.
  - Else if ex_fwd_valid && ex_fwd_rd==rs_s: use ex_fwd_data.
  - Else if mem_fwd_valid && mem_fwd_rd==rs_s: use mem_fwd_data.
  - Else: use rf_rdata_s.
  - EX has priority over MEM.
- Hazard, evaluated on sources where in_use_s=1 and rs_s!=0:
  - EX match with ex_fwd_is_load=1, or
  - MEM match (and no EX match) with mem_fwd_data_ok=0.
- Ready: in_ready = !rst && !flush && !hazard && (!out_valid || out_ready). Combinational; no bubble when EX drains every cycle.
- Accept (in_valid && in_ready): on the next posedge, output registers load and out_valid=1.
- Drain: out_valid && out_ready && no accept -> out_valid=0.
- Stall: out_valid && !out_ready -> all out_* held stable.
- Flush: out_valid<=0 and no accept that cycle. Output data registers may hold stale values.
- Stall counter: increments when in_valid && hazard && !flush; saturates at all-ones and never wraps.
- Latency: one cycle from accept to out_valid.

Test Plan:
- Back-to-back pipeline flow: rs1=5, rs2=6 with no forwarding and rf_rdata1=0x11, rf_rdata2=0x22, out_ready=1 -> out_op1=0x11, out_op2=0x22 one cycle later; in_ready stays 1 each cycle.
- EX/MEM priority: EX rd=5 data=0xAAAA and MEM rd=5 data=0xBBBB, instruction rs1=5 -> out_op1=0xAAAA. Drop EX valid -> out_op1=0xBBBB.
- Load-use: EX rd=7 with is_load=1, instruction rs2=7 use_rs2=1 -> in_ready=0 and stall_cnt+1 for that cycle. Next cycle MEM rd=7 data_ok=1 data=0x1234 -> accepted, out_op2=0x1234.
- x0 and unused sources: rs1=0 with EX rd=0 is_load=1 -> no stall, out_op1=0. use_rs2=0 with rs2 matching a pending load -> no stall.
- Backpressure and flush: out_ready=0 for 3 cycles -> outputs held and in_ready=0. Assert flush -> out_valid=0 next cycle and no accept during the flush cycle.
- Reset mid-operation: out_valid=1 and stall_cnt=9, assert rst -> next cycle out_valid=0, stall_cnt=0, all out_* = 0.
